// File: rtl/memory_port_ctrl_pkg.sv
// Shared widths, BIST state encoding and march-phase data patterns for memory_port_ctrl.
package memory_port_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W    = 6;
  localparam int unsigned DEF_DATA_W    = 7;
  localparam int unsigned DEF_RSP_DEPTH = 3;

  typedef enum logic [2:0] {
    BIST_IDLE,
    BIST_W0_UP,
    BIST_R0W1_UP,
    BIST_R1W0_DN,
    BIST_R0_UP,
    BIST_CHK,
    BIST_DONE
  } bist_state_e;

  // Per-phase bit value, replicated across the data width by the user.
  localparam logic W0_WR_BIT   = 1'b0;
  localparam logic R0W1_RD_BIT = 1'b0;
  localparam logic R0W1_WR_BIT = 1'b1;
  localparam logic R1W0_RD_BIT = 1'b1;
  localparam logic R1W0_WR_BIT = 1'b0;
  localparam logic R0_RD_BIT   = 1'b0;

endpackage

// File: rtl/memory_port_rsp_fifo.sv
// Small first-word-fall-through FIFO holding read responses; async active-low reset.
module memory_port_rsp_fifo #(
  parameter  int unsigned DEPTH = 3,
  parameter  int unsigned WIDTH = 7,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_pop   = i_pop && (r_count != '0);
  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/memory_port_ctrl.sv
// Valid/ready front end for a single-port SRAM macro with 2-cycle read return.
// Optional March BIST engine enabled by defining MEMORY_PORT_CTRL_BIST_EN.
module memory_port_ctrl
  import memory_port_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W    = DEF_ADDR_W,
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned RSP_DEPTH = DEF_RSP_DEPTH
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_data_i,
  input  logic [DATA_W-1:0] req_mask_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              mem_ce_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wd_o,
  output logic [DATA_W-1:0] mem_wmask_o,
  input  logic [DATA_W-1:0] mem_rd_i,
  input  logic              bist_start_i,
  output logic              bist_busy_o,
  output logic              bist_done_o,
  output logic              bist_fail_o
);

  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned OCC_W = CNT_W + 1;

  logic [CNT_W-1:0]  w_count;
  logic              w_rsp_valid;
  logic              w_accept;
  logic              w_credit;
  logic              r_inflight;

  logic              w_bist_busy;
  logic              w_bist_ce;
  logic              w_bist_we;
  logic [ADDR_W-1:0] w_bist_addr;
  logic [DATA_W-1:0] w_bist_wd;

  // Credit covers queued responses plus the read whose data arrives next cycle.
  assign w_credit    = (OCC_W'(w_count) + OCC_W'(r_inflight)) < OCC_W'(RSP_DEPTH);
  assign req_ready_o = !w_bist_busy && w_credit;
  assign w_accept    = req_valid_i && req_ready_o;
  assign rsp_valid_o = w_rsp_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_accept && !req_we_i;
    end
  end

  memory_port_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_W)
  ) u_rsp_fifo (
    .i_clk   (clk_i),
    .i_rst_n (rst_ni),
    .i_push  (r_inflight),
    .i_data  (mem_rd_i),
    .i_pop   (rsp_ready_i),
    .o_data  (rsp_data_o),
    .o_valid (w_rsp_valid),
    .o_count (w_count)
  );

  // Macro port: BIST owns the port while busy, otherwise accepted requests pass through.
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wd_o    = '0;
    mem_wmask_o = '0;
    if (w_bist_busy) begin
      mem_ce_o    = w_bist_ce;
      mem_we_o    = w_bist_we;
      mem_addr_o  = w_bist_addr;
      mem_wd_o    = w_bist_wd;
      mem_wmask_o = '1;
    end else if (w_accept) begin
      mem_ce_o    = 1'b1;
      mem_we_o    = req_we_i;
      mem_addr_o  = req_addr_i;
      mem_wd_o    = req_data_i;
      mem_wmask_o = req_mask_i;
    end
  end

`ifdef MEMORY_PORT_CTRL_BIST_EN

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  bist_state_e       r_bist_state;
  logic [ADDR_W-1:0] r_bist_addr;
  logic              r_bist_wr;
  logic              r_cmp_valid;
  logic              r_cmp_bit;
  logic              r_bist_busy;
  logic              r_bist_done;
  logic              r_bist_fail;
  logic              w_bist_start;
  logic              w_bist_rd;
  logic              w_bist_rd_bit;

  assign w_bist_start = bist_start_i && (w_count == '0) && !r_inflight &&
                        ((r_bist_state == BIST_IDLE) || (r_bist_state == BIST_DONE));
  assign w_bist_busy  = r_bist_busy;
  assign w_bist_addr  = r_bist_addr;
  assign bist_busy_o  = r_bist_busy;
  assign bist_done_o  = r_bist_done;
  assign bist_fail_o  = r_bist_fail;

  // Port command for the current march element; paired phases alternate read then write.
  always_comb begin
    w_bist_ce     = 1'b0;
    w_bist_we     = 1'b0;
    w_bist_wd     = '0;
    w_bist_rd     = 1'b0;
    w_bist_rd_bit = 1'b0;
    unique case (r_bist_state)
      BIST_W0_UP: begin
        w_bist_ce = 1'b1;
        w_bist_we = 1'b1;
        w_bist_wd = {DATA_W{W0_WR_BIT}};
      end
      BIST_R0W1_UP: begin
        w_bist_ce     = 1'b1;
        w_bist_we     = r_bist_wr;
        w_bist_wd     = {DATA_W{R0W1_WR_BIT}};
        w_bist_rd     = !r_bist_wr;
        w_bist_rd_bit = R0W1_RD_BIT;
      end
      BIST_R1W0_DN: begin
        w_bist_ce     = 1'b1;
        w_bist_we     = r_bist_wr;
        w_bist_wd     = {DATA_W{R1W0_WR_BIT}};
        w_bist_rd     = !r_bist_wr;
        w_bist_rd_bit = R1W0_RD_BIT;
      end
      BIST_R0_UP: begin
        w_bist_ce     = 1'b1;
        w_bist_rd     = 1'b1;
        w_bist_rd_bit = R0_RD_BIT;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_bist_state <= BIST_IDLE;
      r_bist_addr  <= '0;
      r_bist_wr    <= 1'b0;
      r_cmp_valid  <= 1'b0;
      r_cmp_bit    <= 1'b0;
      r_bist_busy  <= 1'b0;
      r_bist_done  <= 1'b0;
      r_bist_fail  <= 1'b0;
    end else begin
      r_cmp_valid <= w_bist_rd;
      r_cmp_bit   <= w_bist_rd_bit;
      if (r_cmp_valid && (mem_rd_i != {DATA_W{r_cmp_bit}})) begin
        r_bist_fail <= 1'b1;
      end
      unique case (r_bist_state)
        BIST_IDLE, BIST_DONE: begin
          if (w_bist_start) begin
            r_bist_state <= BIST_W0_UP;
            r_bist_addr  <= '0;
            r_bist_wr    <= 1'b0;
            r_bist_busy  <= 1'b1;
            r_bist_done  <= 1'b0;
            r_bist_fail  <= 1'b0;
          end
        end
        BIST_W0_UP: begin
          r_bist_addr <= r_bist_addr + ADDR_W'(1);
          if (r_bist_addr == ADDR_MAX) begin
            r_bist_state <= BIST_R0W1_UP;
          end
        end
        BIST_R0W1_UP: begin
          r_bist_wr <= !r_bist_wr;
          if (r_bist_wr) begin
            if (r_bist_addr == ADDR_MAX) begin
              r_bist_state <= BIST_R1W0_DN;
            end else begin
              r_bist_addr <= r_bist_addr + ADDR_W'(1);
            end
          end
        end
        BIST_R1W0_DN: begin
          r_bist_wr <= !r_bist_wr;
          if (r_bist_wr) begin
            r_bist_addr <= r_bist_addr - ADDR_W'(1);
            if (r_bist_addr == '0) begin
              r_bist_state <= BIST_R0_UP;
              r_bist_addr  <= '0;
            end
          end
        end
        BIST_R0_UP: begin
          r_bist_addr <= r_bist_addr + ADDR_W'(1);
          if (r_bist_addr == ADDR_MAX) begin
            r_bist_state <= BIST_CHK;
          end
        end
        BIST_CHK: begin
          r_bist_state <= BIST_DONE;
          r_bist_busy  <= 1'b0;
          r_bist_done  <= 1'b1;
        end
        default: r_bist_state <= BIST_IDLE;
      endcase
    end
  end

`else

  logic w_unused_bist_start;

  assign w_unused_bist_start = bist_start_i;
  assign w_bist_busy         = 1'b0;
  assign w_bist_ce           = 1'b0;
  assign w_bist_we           = 1'b0;
  assign w_bist_addr         = '0;
  assign w_bist_wd           = '0;
  assign bist_busy_o         = 1'b0;
  assign bist_done_o         = 1'b0;
  assign bist_fail_o         = 1'b0;

`endif

endmodule

// File: tb/tb_memory_port_ctrl.sv
// Self-checking bench for memory_port_ctrl: SRAM behavioural model plus request-order scoreboard.
module tb_memory_port_ctrl;

  localparam int AW = 6;
  localparam int DW = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_data = '0;
  logic [DW-1:0] req_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          mem_ce, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_wmask;
  logic [DW-1:0] sram_rd = '0;
  logic          bist_start = 1'b0;
  logic          bist_busy, bist_done, bist_fail;

  int n_checks = 0;
  int n_fail   = 0;

  // Scoreboard state: architectural memory image, expected responses, outstanding reads.
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_d;
  int            outst = 0;
  bit            mon_en = 1'b1;
  bit            stuck_en = 1'b0;
  logic [DW-1:0] sram [64];

  always #5 clk = ~clk;

  memory_port_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_we_i    (req_we),
    .req_addr_i  (req_addr),
    .req_data_i  (req_data),
    .req_mask_i  (req_mask),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_data_o  (rsp_data),
    .mem_ce_o    (mem_ce),
    .mem_we_o    (mem_we),
    .mem_addr_o  (mem_addr),
    .mem_wd_o    (mem_wd),
    .mem_wmask_o (mem_wmask),
    .mem_rd_i    (sram_rd),
    .bist_start_i(bist_start),
    .bist_busy_o (bist_busy),
    .bist_done_o (bist_done),
    .bist_fail_o (bist_fail)
  );

  // Single-port SRAM with one-cycle read; optional stuck-at-1 on bit 2 of word 17.
  always @(posedge clk) begin
    if (mem_ce) begin
      if (mem_we) sram[mem_addr] <= (sram[mem_addr] & ~mem_wmask) | (mem_wd & mem_wmask);
      else        sram_rd <= sram[mem_addr] | ((stuck_en && mem_addr == 6'd17) ? 7'h04 : 7'h00);
    end
  end

  // Scoreboard: credit-based ready and in-order read data.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      outst = 0;
    end else if (mon_en) begin
      n_checks++;
      if (req_ready !== (outst < 3)) begin
        n_fail++;
        $display("FAIL ready_credit: got %b expected %b (outstanding %0d)", req_ready, (outst < 3), outst);
      end
      if (rsp_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL rsp_spurious: got valid data %h, expected no response", rsp_data);
        end else if (rsp_data !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rsp_order: got %h expected %h", rsp_data, exp_q[0]);
        end
        if (rsp_ready && exp_q.size() != 0) begin
          exp_d = exp_q.pop_front();
          outst--;
        end
      end
      if (req_valid && req_ready) begin
        if (req_we) ref_mem[req_addr] = (ref_mem[req_addr] & ~req_mask) | (req_data & req_mask);
        else begin
          exp_q.push_back(ref_mem[req_addr]);
          outst++;
        end
      end
    end
  end

  task automatic set_req(input bit v, input bit we, input int a, input int d, input int m);
    req_valid = v;
    req_we    = we;
    req_addr  = AW'(a);
    req_data  = DW'(d);
    req_mask  = DW'(m);
  endtask

  task automatic do_req(input bit we, input int a, input int d, input int m);
    int t = 0;
    @(posedge clk); #1;
    set_req(1'b1, we, a, d, m);
    @(negedge clk);
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      n_checks++; n_fail++;
      $display("FAIL req_timeout: got ready=0 for 50 cycles, expected acceptance");
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({rsp_valid, rsp_data, mem_ce, mem_we, mem_addr, mem_wd, mem_wmask} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got valid=%b data=%h ce=%b we=%b addr=%h wd=%h wm=%h, expected all 0",
               rsp_valid, rsp_data, mem_ce, mem_we, mem_addr, mem_wd, mem_wmask);
    end
    n_checks++;
    if ({req_ready, bist_busy, bist_done, bist_fail} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_status: got ready/busy/done/fail=%b expected 1000",
               {req_ready, bist_busy, bist_done, bist_fail});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    set_req(1'b1, 1'b1, 3, 'h55, 'h7F);
    #1;
    n_checks++;
    if ({mem_ce, mem_we, mem_addr, mem_wd, mem_wmask} !== {1'b1, 1'b1, 6'd3, 7'h55, 7'h7F}) begin
      n_fail++;
      $display("FAIL wr_passthru: got ce=%b we=%b addr=%h wd=%h wm=%h expected 1 1 03 55 7f",
               mem_ce, mem_we, mem_addr, mem_wd, mem_wmask);
    end
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 3, 0, 'h7F);
    #1;
    n_checks++;
    if ({mem_ce, mem_we, mem_addr} !== {1'b1, 1'b0, 6'd3}) begin
      n_fail++;
      $display("FAIL rd_passthru: got ce=%b we=%b addr=%h expected 1 0 03", mem_ce, mem_we, mem_addr);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 0, 0, 0);
    #1;
    n_checks++;
    if ({mem_ce, mem_we, mem_addr, mem_wd, mem_wmask} !== '0) begin
      n_fail++;
      $display("FAIL idle_port: got ce=%b we=%b addr=%h wd=%h wm=%h expected all 0",
               mem_ce, mem_we, mem_addr, mem_wd, mem_wmask);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rd_latency_early: got rsp_valid=%b one cycle after accept, expected 0", rsp_valid);
    end
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 7'h55) begin
      n_fail++;
      $display("FAIL rd_latency2: got valid=%b data=%h expected valid=1 data=55", rsp_valid, rsp_data);
    end
  endtask

  task automatic test_mask();
    int t = 0;
    do_req(1'b1, 10, 'h7F, 'h7F);
    do_req(1'b1, 10, 'h00, 'h0F);
    do_req(1'b0, 10, 0, 0);
    @(negedge clk);
    while (!rsp_valid && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_data !== 7'h70) begin
      n_fail++;
      $display("FAIL mask_write: got valid=%b data=%h expected valid=1 data=70", rsp_valid, rsp_data);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int first_k = -1;
    int n_rsp = 0;
    int last_k = -1;
    rsp_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (k < 8)       set_req(1'b1, 1'b1, k, k + 1, 'h7F);
      else if (k < 16) set_req(1'b1, 1'b0, k - 8, 0, 0);
      else             set_req(1'b0, 1'b0, 0, 0, 0);
      @(negedge clk);
      if (k < 16) begin
        n_checks++;
        if (req_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_ready: cycle %0d got ready=%b expected 1", k, req_ready);
        end
      end
      if (rsp_valid) begin
        if (first_k < 0) first_k = k;
        last_k = k;
        n_checks++;
        if (rsp_data !== DW'(n_rsp + 1)) begin
          n_fail++;
          $display("FAIL b2b_data: rsp %0d got %h expected %h", n_rsp, rsp_data, DW'(n_rsp + 1));
        end
        n_rsp++;
      end
    end
    n_checks++;
    if (n_rsp != 8 || first_k != 10 || last_k != 17) begin
      n_fail++;
      $display("FAIL b2b_stream: got %0d rsps in cycles %0d..%0d expected 8 in cycles 10..17",
               n_rsp, first_k, last_k);
    end
  endtask

  task automatic test_backpressure();
    int acc = 0;
    int drained = 0;
    rsp_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      set_req(1'b1, 1'b0, acc, 0, 0);
      @(negedge clk);
      if (req_ready) acc++;
    end
    n_checks++;
    if (acc != 3 || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept: got %0d accepted ready=%b expected 3 accepted ready=0", acc, req_ready);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 0, 0, 0);
    rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        n_checks++;
        if (rsp_data !== DW'(drained + 1)) begin
          n_fail++;
          $display("FAIL bp_drain_data: rsp %0d got %h expected %h", drained, rsp_data, DW'(drained + 1));
        end
        drained++;
      end
    end
    n_checks++;
    if (drained != 3 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_drain: got %0d drained ready=%b expected 3 drained ready=1", drained, req_ready);
    end
  endtask

  task automatic test_random();
    rsp_ready = 1'b1;
    for (int a = 0; a < 64; a++) begin
      @(posedge clk); #1;
      set_req(1'b1, 1'b1, a, int'($urandom_range(0, 127)), 'h7F);
    end
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      set_req($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 63)),
              int'($urandom_range(0, 127)), int'($urandom_range(0, 127)));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 0, 0, 0);
    rsp_ready = 1'b1;
    repeat (8) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rand_drain: got %0d missing rsps valid=%b expected 0 and 0", exp_q.size(), rsp_valid);
    end
  endtask

  task automatic test_reset_midflight();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    set_req(1'b1, 1'b0, 5, 0, 0);
    @(posedge clk); #1;
    set_req(1'b0, 1'b0, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL reset_discard: cycle %0d got valid=%b ready=%b expected 0 1", k, rsp_valid, req_ready);
      end
    end
  endtask

  task automatic test_bist();
`ifdef MEMORY_PORT_CTRL_BIST_EN
    int busy_cyc;
    mon_en = 1'b0;
    for (int run = 0; run < 2; run++) begin
      stuck_en = (run == 1);
      busy_cyc = 0;
      @(posedge clk); #1;
      bist_start = 1'b1;
      @(posedge clk); #1;
      bist_start = 1'b0;
      @(negedge clk);
      while (bist_busy && busy_cyc < 1000) begin
        busy_cyc++;
        n_checks++;
        if (req_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bist_block: got ready=%b during BIST expected 0", req_ready);
        end
        @(negedge clk);
      end
      n_checks++;
      if (busy_cyc != 385 || bist_done !== 1'b1 || bist_fail !== (run == 1)) begin
        n_fail++;
        $display("FAIL bist_run%0d: got busy=%0d done=%b fail=%b expected 385 1 %b",
                 run, busy_cyc, bist_done, bist_fail, (run == 1));
      end
    end
    stuck_en = 1'b0;
`else
    @(posedge clk); #1;
    bist_start = 1'b1;
    @(posedge clk); #1;
    bist_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({bist_busy, bist_done, bist_fail, req_ready} !== 4'b0001) begin
        n_fail++;
        $display("FAIL bist_tied: got busy/done/fail/ready=%b expected 0001",
                 {bist_busy, bist_done, bist_fail, req_ready});
      end
    end
`endif
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_mask();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_bist();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memory_port_ctrl.md
# memory_port_ctrl

Initiator-side controller for the single-port 64x7 SRAM macro wrapper (`clk`/`we_in`/`ce_in`/`addr_in`/`wd_in`/`w_mask_in`/`rd_out`). It converts a valid/ready request stream into macro port cycles and handles the macro's one-cycle read latency. Read data is returned on a valid/ready response stream through a small buffer. It sits between client logic and the memory wrapper in the rmp test designs, and optionally carries a March-style BIST engine.

## Interface
- ADDR_W, 6, address width (64 words)
- DATA_W, 7, data/mask width
- RSP_DEPTH, 3, response FIFO depth; must be at least 3 for full read throughput
- clk_i  in  1  single clock; all logic is rising-edge
- rst_ni  in  1  reset, asynchronous, active-low
- req_valid_i / req_ready_o  in/out  1  request handshake
- req_we_i  in  1  1 = write, 0 = read
- req_addr_i  in  ADDR_W  word address
- req_data_i  in  DATA_W  write data
- req_mask_i  in  DATA_W  write bit-enable; 1 = write that bit
- rsp_valid_o / rsp_ready_i  out/in  1  read-response handshake
- rsp_data_o  out  DATA_W  read data
- mem_ce_o, mem_we_o  out  1  macro chip enable / write enable
- mem_addr_o  out  ADDR_W  macro address
- mem_wd_o, mem_wmask_o  out  DATA_W  macro write data / mask
- mem_rd_i  in  DATA_W  macro read data, valid the cycle after the read edge
- bist_start_i  in  1  BIST start pulse
- bist_busy_o, bist_done_o, bist_fail_o  out  1  BIST status

## Operation
**Request acceptance**
- Accept when req_valid_i & req_ready_o.
- req_ready_o = !bist_busy_o & (fifo_count + inflight < RSP_DEPTH). `inflight` is a 1-bit flag for a read issued in the previous cycle.

**Macro port driving**
- The mem_* outputs are combinational from the request on acceptance: mem_ce_o = accept; mem_we_o = req_we_i.
- Addr, data and mask pass straight through.
- When there is no access, mem_ce_o = mem_we_o = 0 and addr/wd/wmask = 0.

**Writes**
- A write produces no response.

**Reads**
- A read sets `inflight`.
- In the next cycle, mem_rd_i is pushed into the response FIFO and `inflight` clears.

**Response FIFO**
- Registered, first-word-fall-through output.
- rsp_data_o = head entry; rsp_valid_o = (count != 0).
- Pop on rsp_valid_o & rsp_ready_i.
- Simultaneous push and pop: count unchanged, order preserved.
- The credit rule guarantees push never occurs when full.

**Ordering**
- Responses are returned strictly in request order.

**Reset behaviour**
- Asserting rst_ni mid-operation discards the in-flight read and all FIFO contents. Nothing is replayed after reset.

**Reset values**
- rsp_valid_o = 0, rsp_data_o = 0.
- mem_ce_o = mem_we_o = 0, mem_addr_o = 0, mem_wd_o = 0, mem_wmask_o = 0.
- req_ready_o = 1 (combinational from reset state).
- bist_busy_o = bist_done_o = bist_fail_o = 0.

## Timing
- Read accepted in cycle N → macro samples at edge ending N → mem_rd_i valid in N+1 → rsp_valid_o high in N+2 (when the FIFO was empty).
- Read latency is therefore 2 cycles.
- Back-to-back reads sustain 1 request/cycle while rsp_ready_i = 1.
- A write takes effect at the edge ending its acceptance cycle. A read accepted in the next cycle returns the new data.
- With rsp_ready_i = 0: at most RSP_DEPTH reads are accepted, then req_ready_o = 0 until a pop.

## Configuration
**MEMORY_PORT_CTRL_BIST_EN defined**
- BIST FSM states: IDLE → W0↑ → R0W1↑ → R1W0↓ → R0↑ → CHK → DONE.
- Starting: bist_start_i is honoured only in IDLE/DONE with count = 0 and !inflight; otherwise it is ignored. A start clears bist_done_o and bist_fail_o and sets bist_busy_o.
- W0: 1 cycle per address. Rxwy: read cycle then write cycle per address. R0: 1 cycle per address. ↑ = address 0→63, ↓ = 63→0.
- Masks are all-ones during BIST.
- Compare: each read result is checked in the following cycle against the expected all-zeros/all-ones pattern. Any mismatch sets bist_fail_o, which is sticky.
- CHK: one cycle for the final compare.
- DONE: bist_busy_o = 0 and bist_done_o = 1, held until the next start.
- The BIST drives the mem_* outputs; client requests are blocked while busy.
- Total run is 64 + 128 + 128 + 64 + 1 = 385 cycles from start to bist_done_o.

**Not defined**
- The BIST ports remain. bist_busy_o, bist_done_o and bist_fail_o are tied to 0 and bist_start_i is ignored.

## Structure
- Package `memory_port_ctrl_pkg`: ADDR_W/DATA_W defaults, the `bist_state_e` enum, and the march-phase expected-pattern constants.
- Sub-module `memory_port_rsp_fifo`: parameterised depth/width, push/pop/count, async active-low reset.

## Test plan
- Write 0x55 to addr 3 with mask 0x7F, then read addr 3 → rsp_data_o = 0x55, exactly 2 cycles after the read acceptance.
- Write 0x7F to addr 10; write 0x00 with mask 0x0F; read → 0x70.
- 8 back-to-back reads of addrs 0..7 (preloaded with addr+1) with rsp_ready_i = 1 → 8 responses 1..8 on consecutive cycles, no bubbles.
- rsp_ready_i = 0 while issuing reads → exactly 3 accepted, req_ready_o = 0; release → in-order drain, then ready reasserts.
- Reset asserted the cycle after a read is accepted → after release rsp_valid_o stays 0 and req_ready_o = 1.
- BIST_EN with a fault-free model: pulse start → busy for 385 cycles, done = 1, fail = 0. With a bit-2 stuck-at-1 at addr 17 → fail = 1.
